// File: rtl/player_pkg.sv
// Shared encodings for the player step scheduler.
//   DIR_*   : bit positions of the direction buttons / step pulses
//   state_e : scheduler FSM states
package player_pkg;

  localparam int unsigned DIR_W = 2;
  localparam int unsigned NDIR  = 4;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb4.sv
// 4-way round-robin priority picker (combinational).
//   req       : request vector
//   ptr       : index with highest priority this time; search wraps 3->0
//   gnt_idx   : index of the winning request
//   gnt_valid : any request present
module rr_arb4
  import player_pkg::*;
(
  input  logic [NDIR-1:0]  req,
  input  logic [DIR_W-1:0] ptr,
  output logic [DIR_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [DIR_W-1:0] idx;

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = int'(NDIR) - 1; i >= 0; i--) begin
      idx = ptr + DIR_W'(i);
      if (req[idx]) begin
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_move_sched.sv
// Converts held direction buttons into single-cycle step pulses for the
// player object: one step on press, hold-to-repeat after a delay, round-robin
// between simultaneously held directions, per-direction step enables.
//   btnClk2      : clock
//   rst          : synchronous active-high reset
//   btns         : held requests [0]=up [1]=down [2]=left [3]=right
//   *Enable      : per-direction step permission
//   freeze       : pause scheduling; state and counters hold
//   move_o       : one-hot step pulse
//   moving       : a direction is currently granted
//   blocked      : a step fell due but its enable was low
//   step_count   : issued steps, wrapping
module player_move_sched
  import player_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             btnClk2,
  input  logic             rst,
  input  logic [NDIR-1:0]  btns,
  input  logic             upEnable,
  input  logic             downEnable,
  input  logic             leftEnable,
  input  logic             rightEnable,
  input  logic             freeze,
  output logic [NDIR-1:0]  move_o,
  output logic             moving,
  output logic             blocked,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

  state_e            state_q, state_d;
  logic [DIR_W-1:0]  grant_q, grant_d;
  logic [DIR_W-1:0]  rr_q, rr_d;
  logic [TMR_W-1:0]  cnt_q, cnt_d;
  logic [NDIR-1:0]   move_q, move_d;
  logic              moving_q, moving_d;
  logic              blocked_q, blocked_d;
  logic [CNT_W-1:0]  steps_q, steps_d;

  logic [NDIR-1:0]   en;
  logic [DIR_W-1:0]  arb_idx;
  logic              arb_valid;
  logic              due;
  logic              held;

  always_comb begin
    en            = '0;
    en[DIR_UP]    = upEnable;
    en[DIR_DOWN]  = downEnable;
    en[DIR_LEFT]  = leftEnable;
    en[DIR_RIGHT] = rightEnable;
  end

  assign held = btns[grant_q];

  rr_arb4 u_arb (
    .req       (btns),
    .ptr       (rr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // State register and registered outputs.
  always_ff @(posedge btnClk2) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      move_q    <= '0;
      moving_q  <= 1'b0;
      blocked_q <= 1'b0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      moving_q  <= moving_d;
      blocked_q <= blocked_d;
      steps_q   <= steps_d;
    end
  end

  // Next-state: grant, press step, delay then periodic repeat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    due     = 1'b0;

    if (freeze) begin
      // Timing holds, but a release still drops the grant.
      if (state_q != ST_IDLE && !held) begin
        state_d = ST_IDLE;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_d = arb_idx;
            rr_d    = arb_idx + DIR_W'(1);
            state_d = ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (!held) begin
            state_d = ST_IDLE;
          end else begin
            due     = 1'b1;
            cnt_d   = DELAY_LOAD;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!held) begin
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            due     = 1'b1;
            cnt_d   = RATE_LOAD;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q - TMR_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A due step either issues or is reported as blocked; timing is unaffected.
  always_comb begin
    move_d    = '0;
    blocked_d = 1'b0;
    steps_d   = steps_q;
    moving_d  = (state_d != ST_IDLE);
    if (due) begin
      if (en[grant_q]) begin
        move_d  = NDIR'(1) << grant_q;
        steps_d = steps_q + CNT_W'(1);
      end else begin
        blocked_d = 1'b1;
      end
    end
  end

  assign move_o     = move_q;
  assign moving     = moving_q;
  assign blocked    = blocked_q;
  assign step_count = steps_q;

endmodule

// File: tb/tb_player_move_sched.sv
// Directed bench for player_move_sched with REPEAT_DELAY=4, REPEAT_RATE=2.
// Cycle 0 is the cycle in which a press is first presented; cycle c is
// observed #1 after the c-th following rising edge.
module tb_player_move_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  btns;
  logic        up_en, down_en, left_en, right_en;
  logic        freeze;
  logic [3:0]  move_o;
  logic        moving;
  logic        blocked;
  logic [15:0] step_count;

  int total;
  int bad;

  player_move_sched #(
    .REPEAT_DELAY (4),
    .REPEAT_RATE  (2),
    .CNT_W        (16)
  ) dut (
    .btnClk2     (clk),
    .rst         (rst),
    .btns        (btns),
    .upEnable    (up_en),
    .downEnable  (down_en),
    .leftEnable  (left_en),
    .rightEnable (right_en),
    .freeze      (freeze),
    .move_o      (move_o),
    .moving      (moving),
    .blocked     (blocked),
    .step_count  (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    btns   = 4'b0000;
    freeze = 1'b0;
    up_en = 1'b1; down_en = 1'b1; left_en = 1'b1; right_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset values
    do_reset();
    chk("rst_move", 32'(move_o), 32'h0);
    chk("rst_moving", 32'(moving), 32'h0);
    chk("rst_blocked", 32'(blocked), 32'h0);
    chk("rst_count", 32'(step_count), 32'h0);

    // 1: hold up through cycle 12 -> steps at 2,6,8,10,12
    btns = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 13) btns = 4'b0000;
      chk($sformatf("hold_up_c%0d", c), 32'(move_o),
          (c == 2 || c == 6 || c == 8 || c == 10 || c == 12) ? 32'h1 : 32'h0);
      if (c == 1) chk("hold_up_moving", 32'(moving), 32'h1);
    end
    chk("hold_up_count", 32'(step_count), 32'd5);
    chk("hold_up_idle", 32'(moving), 32'h0);

    // 2: short tap on left (press cycle + grant cycle) -> exactly one step
    do_reset();
    btns = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) btns = 4'b0000;
      chk($sformatf("tap_c%0d", c), 32'(move_o), (c == 2) ? 32'h4 : 32'h0);
    end
    chk("tap_count", 32'(step_count), 32'd1);

    // 3: up+right from rr_ptr=0 -> up first, then right after the IDLE gap
    do_reset();
    btns = 4'b1001;
    tick();
    chk("rr_c1_moving", 32'(moving), 32'h1);
    tick();
    chk("rr_c2_up", 32'(move_o), 32'h1);
    btns = 4'b1000;
    tick();
    chk("rr_c3_gap_moving", 32'(moving), 32'h0);
    chk("rr_c3_gap_move", 32'(move_o), 32'h0);
    tick();
    chk("rr_c4_grant", 32'(moving), 32'h1);
    tick();
    chk("rr_c5_right", 32'(move_o), 32'h8);
    btns = 4'b0000;
    tick();
    tick();
    // pointer wrapped back to up: up wins again over right
    btns = 4'b1001;
    tick();
    tick();
    chk("rr_wrap_up", 32'(move_o), 32'h1);
    btns = 4'b0000;
    tick();
    tick();

    // 4a: down held with its enable low -> blocked at 2,6,8, no steps
    do_reset();
    down_en = 1'b0;
    btns = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 9) btns = 4'b0000;
      chk($sformatf("blk_c%0d", c), 32'(blocked),
          (c == 2 || c == 6 || c == 8) ? 32'h1 : 32'h0);
      chk($sformatf("blk_move_c%0d", c), 32'(move_o), 32'h0);
    end
    chk("blk_count", 32'(step_count), 32'h0);

    // 4b: enable raised in cycle 7 -> the step due then issues at cycle 8
    do_reset();
    down_en = 1'b0;
    btns = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 7) down_en = 1'b1;
      chk($sformatf("en_blk_c%0d", c), 32'(blocked), (c == 2 || c == 6) ? 32'h1 : 32'h0);
      chk($sformatf("en_move_c%0d", c), 32'(move_o), (c == 8) ? 32'h2 : 32'h0);
    end
    chk("en_count", 32'(step_count), 32'd1);
    btns = 4'b0000;
    tick();

    // 5: left held, freeze cycles 4-9 -> repeats shifted by 6 (12, 14)
    do_reset();
    btns = 4'b0100;
    for (int c = 1; c <= 14; c++) begin
      tick();
      freeze = (c >= 4 && c <= 9);
      chk($sformatf("frz_c%0d", c), 32'(move_o),
          (c == 2 || c == 12 || c == 14) ? 32'h4 : 32'h0);
      if (c == 7) chk("frz_moving", 32'(moving), 32'h1);
    end
    chk("frz_count", 32'(step_count), 32'd3);
    btns = 4'b0000;
    tick();

    // 6: reset mid-hold suppresses the pending step; restart 2 cycles later
    do_reset();
    btns = 4'b0001;
    for (int c = 1; c <= 5; c++) tick();
    chk("mid_rst_pre_count", 32'(step_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_move", 32'(move_o), 32'h0);
    chk("mid_rst_moving", 32'(moving), 32'h0);
    chk("mid_rst_blocked", 32'(blocked), 32'h0);
    chk("mid_rst_count", 32'(step_count), 32'h0);
    tick();
    chk("mid_rst_c7", 32'(move_o), 32'h0);
    tick();
    chk("mid_rst_c8", 32'(move_o), 32'h1);
    btns = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
